// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//   Drives the 2-bit select of an 8-bit 4:1 input mux. In MANUAL mode the
//   select is stepped by two debounced push buttons (next / prev); in AUTO
//   mode a tick counter advances it every AUTO_PERIOD cycles.
//
// Ports
//   clk         in   1  system clock, all state on rising edge
//   rst         in   1  asynchronous active-high reset
//   btn_next    in   1  raw push button, advance sel
//   btn_prev    in   1  raw push button, retreat sel
//   auto_en     in   1  raw slide switch, 1 = auto-scan, 0 = manual
//   sel         out  2  registered mux select
//   sel_change  out  1  one-cycle pulse on the edge sel takes a new value
//   auto_mode   out  1  registered, high while the FSM is in AUTO
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_PERIOD     = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    output logic [1:0] sel,
    output logic       sel_change,
    output logic       auto_mode
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(AUTO_PERIOD - 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    // Bit mapping for the synchronizer vectors: 0 = next, 1 = prev, 2 = auto_en.
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [1:0]      r_db;
    logic [1:0]      r_db_q;
    logic [DB_W-1:0] r_db_cnt [0:1];
    logic [TK_W-1:0] r_tick;
    state_t          r_state;

    state_t          w_state_nxt;
    logic [1:0]      w_press;
    logic [1:0]      w_sel_nxt;
    logic            w_chg_nxt;
    logic [TK_W-1:0] w_tick_nxt;

    // Two-flop synchronizer for all raw inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {auto_en, btn_prev, btn_next};
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debouncer: the level is accepted only after an unbroken run
    // of DEBOUNCE_CYCLES cycles disagreeing with the current debounced value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db   <= 2'b00;
            r_db_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= {DB_W{1'b0}};
            end
        end else begin
            r_db_q <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= {DB_W{1'b0}};
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    // Press = rising edge of the debounced level; releases are discarded.
    assign w_press = r_db & ~r_db_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic, following the synchronized slide switch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MANUAL: begin
                if (r_sync2[2]) begin
                    w_state_nxt = ST_AUTO;
                end else begin
                    w_state_nxt = ST_MANUAL;
                end
            end
            ST_AUTO: begin
                if (r_sync2[2]) begin
                    w_state_nxt = ST_AUTO;
                end else begin
                    w_state_nxt = ST_MANUAL;
                end
            end
            default: begin
                w_state_nxt = ST_MANUAL;
            end
        endcase
    end

    // FSM output logic: next select, change pulse and tick counter.
    always_comb begin
        w_sel_nxt  = sel;
        w_chg_nxt  = 1'b0;
        w_tick_nxt = r_tick;
        case (r_state)
            ST_MANUAL: begin
                w_tick_nxt = {TK_W{1'b0}};
                // Simultaneous next and prev presses cancel out.
                if (w_press[0] && !w_press[1]) begin
                    w_sel_nxt = sel + 2'd1;
                    w_chg_nxt = 1'b1;
                end else if (w_press[1] && !w_press[0]) begin
                    w_sel_nxt = sel - 2'd1;
                    w_chg_nxt = 1'b1;
                end else begin
                    w_sel_nxt = sel;
                    w_chg_nxt = 1'b0;
                end
            end
            ST_AUTO: begin
                if (r_tick == TK_LAST) begin
                    w_tick_nxt = {TK_W{1'b0}};
                    w_sel_nxt  = sel + 2'd1;
                    w_chg_nxt  = 1'b1;
                end else begin
                    w_tick_nxt = r_tick + TK_W'(1);
                end
            end
            default: begin
                w_tick_nxt = {TK_W{1'b0}};
                w_sel_nxt  = sel;
                w_chg_nxt  = 1'b0;
            end
        endcase
    end

    // Registered outputs and tick counter; auto_mode tracks the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= 2'd0;
            sel_change <= 1'b0;
            auto_mode  <= 1'b0;
            r_tick     <= {TK_W{1'b0}};
        end else begin
            sel        <= w_sel_nxt;
            sel_change <= w_chg_nxt;
            auto_mode  <= (w_state_nxt == ST_AUTO);
            r_tick     <= w_tick_nxt;
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

    localparam int D = 4;
    localparam int P = 8;

    logic       clk      = 1'b0;
    logic       clk_en   = 1'b0;
    logic       rst      = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en  = 1'b0;
    logic [1:0] sel;
    logic       sel_change;
    logic       auto_mode;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    mux_sel_sequencer #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_en(auto_en), .sel(sel), .sel_change(sel_change), .auto_mode(auto_mode)
    );

    always #10 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw inputs reach the debouncer two edges after being sampled; a level is
    // accepted after D consecutive disagreeing cycles; presses act one edge
    // after the debounced rise. AUTO advances every P-th edge spent in AUTO.
    int       m_sel, m_chg, m_auto, auto_edges;
    logic [2:0] m_s1, m_s2;
    int       deb [2];
    int       debq [2];
    int       run [2];
    int       pn, pp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sel = 0; m_chg = 0; m_auto = 0; auto_edges = 0;
            m_s1 = 3'b000; m_s2 = 3'b000;
            for (int i = 0; i < 2; i++) begin deb[i] = 0; debq[i] = 0; run[i] = 0; end
        end else begin
            pn = (deb[0] == 1 && debq[0] == 0) ? 1 : 0;
            pp = (deb[1] == 1 && debq[1] == 0) ? 1 : 0;
            m_chg = 0;
            if (m_auto == 1) begin
                auto_edges++;
                if (auto_edges % P == 0) begin
                    m_sel = (m_sel + 1) % 4;
                    m_chg = 1;
                end
            end else begin
                auto_edges = 0;
                if (pn != pp) begin
                    m_sel = (pn == 1) ? (m_sel + 1) % 4 : (m_sel + 3) % 4;
                    m_chg = 1;
                end
            end
            m_auto = int'(m_s2[2]);
            for (int i = 0; i < 2; i++) begin
                debq[i] = deb[i];
                if (int'(m_s2[i]) != deb[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        deb[i] = int'(m_s2[i]);
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {auto_en, btn_prev, btn_next};
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("sel", int'(sel), m_sel);
            chk("sel_change", int'(sel_change), m_chg);
            chk("auto_mode", int'(auto_mode), m_auto);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_next();
        btn_next = 1'b1; cyc(10); btn_next = 1'b0; cyc(10);
    endtask

    task automatic count_changes(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sel_change) cnt++;
        end
    endtask

    int lat, cnt, len;

    initial begin
        // 1. reset with no clock running
        #5 rst = 1'b1;
        #1;
        chk("rst_sel", int'(sel), 0);
        chk("rst_chg", int'(sel_change), 0);
        chk("rst_auto", int'(auto_mode), 0);
        chk("rst_model_sel", m_sel, 0);
        #10 clk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        cyc(3);

        // 2. five clean next presses, first one with latency pin
        btn_next = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (sel_change && lat == 0) lat = k;
        end
        btn_next = 1'b0; cyc(10);
        chk("t2_latency", lat, 7);
        chk("t2_first_sel", int'(sel), 1);
        repeat (4) press_next();
        chk("t2_sel", int'(sel), 1);
        chk("t2_model_sel", m_sel, 1);

        // 3. bouncing input, then a clean hold
        repeat (4) begin btn_next = 1'b1; cyc(2); btn_next = 1'b0; cyc(2); end
        cyc(10);
        chk("t3_bounce_sel", int'(sel), 1);
        press_next();
        chk("t3_hold_sel", int'(sel), 2);

        // 4. prev wrap and simultaneous presses
        press_next(); press_next();
        chk("t4_sel0", int'(sel), 0);
        btn_prev = 1'b1; cyc(10); btn_prev = 1'b0; cyc(10);
        chk("t4_prev_wrap", int'(sel), 3);
        btn_next = 1'b1; btn_prev = 1'b1;
        count_changes(10, cnt);
        btn_next = 1'b0; btn_prev = 1'b0;
        count_changes(10, lat);
        chk("t4_both_pulses", cnt + lat, 0);
        chk("t4_both_sel", int'(sel), 3);

        // 5. auto scan with ignored button presses
        auto_en = 1'b1;
        cyc(2);
        chk("t5_auto_early", int'(auto_mode), 0);
        cyc(1);
        chk("t5_auto_on", int'(auto_mode), 1);
        cnt = 0;
        repeat (6) begin
            btn_next = 1'b1;
            for (int k = 0; k < 5; k++) begin @(negedge clk); if (sel_change) cnt++; end
            btn_next = 1'b0;
            for (int k = 0; k < 5; k++) begin @(negedge clk); if (sel_change) cnt++; end
        end
        chk("t5_advances", cnt, 7);
        chk("t5_sel", int'(sel), 2);
        auto_en = 1'b0;
        cyc(20);
        chk("t5_frozen_sel", int'(sel), 2);
        chk("t5_auto_off", int'(auto_mode), 0);

        // 6. reset mid-period with a held button
        auto_en = 1'b1; btn_next = 1'b1;
        cyc(13);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_sel", int'(sel), 0);
        chk("t6_rst_chg", int'(sel_change), 0);
        chk("t6_rst_auto", int'(auto_mode), 0);
        auto_en = 1'b0;
        #4 rst = 1'b0;
        count_changes(20, cnt);
        chk("t6_held_incr", cnt, 1);
        chk("t6_sel", int'(sel), 1);
        btn_next = 1'b0;
        cyc(10);

        // randomized phase, checked by the model every cycle
        repeat (400) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) auto_en = ~auto_en;
            len = auto_en ? $urandom_range(1, 30) : $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) begin
                #3 rst = 1'b1;
                #4 rst = 1'b0;
            end
            cyc(len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
